// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared types, default sizes and FIFO-select helper for the matrix-vector sequencer
package matvec_pkg;

   localparam int MV_DATA_WIDTH = 8;
   localparam int MV_ROWS       = 8;
   localparam int MV_COLS       = 8;
   localparam int MEM_WIDTH     = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_REQ,
      S_WAIT,
      S_UNPACK,
      S_CALC,
      S_DRAIN,
      S_DONE
   } seq_state_t;

   // Bit 0 selects the B FIFO (word 0); bit r+1 selects A FIFO r (word r+1).
   function automatic logic [31:0] fifo_select(input int unsigned word_idx);
      fifo_select = 32'd1 << word_idx;
   endfunction

endpackage

// File: rtl/matvec_sequencer_word_unpacker.sv
// rtl/matvec_sequencer_word_unpacker.sv - 64-bit word to byte serializer with full-flag backpressure
module word_unpacker
   import matvec_pkg::*;
#(
   parameter int DATA_WIDTH = MV_DATA_WIDTH,
   parameter int COLS       = MV_COLS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [MEM_WIDTH-1:0]  data_i,
   input  logic                  full_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  strobe_o,
   output logic                  last_o
);

   localparam int CW = $clog2(COLS + 1);

   logic [MEM_WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 active_q, active_d;

   assign data_o   = sreg_q[DATA_WIDTH-1:0];
   assign strobe_o = active_q & ~full_i;
   assign last_o   = strobe_o & (cnt_q == CW'(COLS - 1));

   // Load a word, or shift one byte out per accepted strobe; a full target holds the current byte.
   always_comb begin
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (load_i) begin
         sreg_d   = data_i;
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (strobe_o) begin
         sreg_d = sreg_q >> DATA_WIDTH;
         cnt_d  = cnt_q + 1'b1;
         if (last_o) begin
            active_d = 1'b0;
         end
      end
   end

   // Serializer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q   <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/matvec_sequencer.sv
// rtl/matvec_sequencer.sv - fill/compute sequencer for the 8x8 matvec engine; SEQ_PERF_EN adds perf counters
module matvec_sequencer
   import matvec_pkg::*;
#(
   parameter int ROWS       = MV_ROWS,
   parameter int COLS       = MV_COLS,
   parameter int DATA_WIDTH = MV_DATA_WIDTH,
   parameter int ADDR_WIDTH = 32,
   parameter int MAC_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   input  logic [MEM_WIDTH-1:0]  mem_readdata,
   input  logic                  mem_readdatavalid,
   input  logic                  mem_waitrequest,
   output logic [DATA_WIDTH-1:0] fifo_wdata,
   output logic [ROWS-1:0]       fifo_wrreq_a,
   output logic                  fifo_wrreq_b,
   input  logic [ROWS-1:0]       fifo_wrfull_a,
   input  logic                  fifo_wrfull_b,
   input  logic                  fifo_rdempty_a0,
   input  logic                  fifo_rdempty_b,
   output logic                  mac_clr,
   output logic                  mac_en
`ifdef SEQ_PERF_EN
   ,
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_stalls
`endif
);

   localparam int IDX_W      = $clog2(ROWS + 1);
   localparam int CNT_W      = $clog2(COLS + 1);
   localparam int DRAIN_CYC  = ROWS - 1 + MAC_LAT;
   localparam int DRAIN_W    = $clog2(DRAIN_CYC + 1) + 1;
   // The drain count starts at the last head enable, so DRAIN itself lasts one cycle less.
   localparam int DRAIN_LAST = (DRAIN_CYC >= 2) ? DRAIN_CYC - 2 : 0;

   seq_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      calc_q, calc_d;
   logic [DRAIN_W-1:0]    drain_q, drain_d;

   logic [31:0] sel;
   logic        tgt_full;
   logic        start_acc;
   logic        unp_load;
   logic        unp_strobe;
   logic        unp_last;

   assign sel       = fifo_select(32'(idx_q));
   assign tgt_full  = sel[0] ? fifo_wrfull_b : |(fifo_wrfull_a & sel[ROWS:1]);
   assign start_acc = start & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign unp_load  = (state_q == S_WAIT) & mem_readdatavalid;

   word_unpacker #(
      .DATA_WIDTH (DATA_WIDTH),
      .COLS       (COLS)
   ) u_unpacker (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (unp_load),
      .data_i   (mem_readdata),
      .full_i   (tgt_full),
      .data_o   (fifo_wdata),
      .strobe_o (unp_strobe),
      .last_o   (unp_last)
   );

   assign fifo_wrreq_b = unp_strobe & sel[0];
   assign fifo_wrreq_a = {ROWS{unp_strobe}} & sel[ROWS:1];
   assign mem_read     = (state_q == S_REQ);
   assign mem_address  = base_q + ADDR_WIDTH'(idx_q);
   assign mac_clr      = (state_q == S_CLEAR);
   assign mac_en       = (state_q == S_CALC) & ~fifo_rdempty_b & ~fifo_rdempty_a0;
   assign done         = (state_q == S_DONE);
   assign busy         = (state_q != S_IDLE) & (state_q != S_DONE);

   // Next-state and counter logic for the fetch / unpack / compute / drain sequence.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      idx_d   = idx_q;
      calc_d  = calc_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_acc) begin
               state_d = S_CLEAR;
               base_d  = base_addr;
               idx_d   = '0;
               calc_d  = '0;
               drain_d = '0;
            end
         end
         S_CLEAR: state_d = S_REQ;
         S_REQ: begin
            if (!mem_waitrequest) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_readdatavalid) state_d = S_UNPACK;
         end
         S_UNPACK: begin
            if (unp_last) begin
               if (idx_q == IDX_W'(ROWS)) begin
                  state_d = S_CALC;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_CALC: begin
            if (mac_en) begin
               calc_d = calc_q + 1'b1;
               if (calc_q == CNT_W'(COLS - 1)) begin
                  drain_d = '0;
                  state_d = (DRAIN_CYC <= 1) ? S_DONE : S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_W'(DRAIN_LAST)) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state registers; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         idx_q   <= '0;
         calc_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         calc_q  <= calc_d;
         drain_q <= drain_d;
      end
   end

`ifdef SEQ_PERF_EN
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [31:0] perf_stalls_q, perf_stalls_d;
   logic        stall;

   // Saturating run-length and stall counters; cleared by an accepted start, frozen outside a run.
   always_comb begin
      stall = ((state_q == S_REQ) & mem_waitrequest)
            | ((state_q == S_UNPACK) & tgt_full)
            | ((state_q == S_CALC) & ~mac_en);
      perf_cycles_d = perf_cycles_q;
      perf_stalls_d = perf_stalls_q;
      if (start_acc) begin
         perf_cycles_d = '0;
         perf_stalls_d = '0;
      end else if (busy) begin
         if (perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 1'b1;
         if (stall && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 1'b1;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_matvec_sequencer.sv
// tb/tb_matvec_sequencer.sv - self-checking bench for matvec_sequencer
module tb_matvec_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic        busy, done;
   logic [31:0] mem_address;
   logic        mem_read;
   logic [63:0] mem_readdata = '0;
   logic        mem_readdatavalid = 1'b0;
   logic        mem_waitrequest = 1'b0;
   logic [7:0]  fifo_wdata;
   logic [7:0]  fifo_wrreq_a;
   logic        fifo_wrreq_b;
   logic [7:0]  fifo_wrfull_a = '0;
   logic        fifo_wrfull_b = 1'b0;
   logic        fifo_rdempty_a0 = 1'b0;
   logic        fifo_rdempty_b = 1'b0;
   logic        mac_clr, mac_en;
`ifdef SEQ_PERF_EN
   logic [31:0] perf_cycles, perf_stalls;
`endif

   matvec_sequencer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .base_addr         (base_addr),
      .busy              (busy),
      .done              (done),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .mem_waitrequest   (mem_waitrequest),
      .fifo_wdata        (fifo_wdata),
      .fifo_wrreq_a      (fifo_wrreq_a),
      .fifo_wrreq_b      (fifo_wrreq_b),
      .fifo_wrfull_a     (fifo_wrfull_a),
      .fifo_wrfull_b     (fifo_wrfull_b),
      .fifo_rdempty_a0   (fifo_rdempty_a0),
      .fifo_rdempty_b    (fifo_rdempty_b),
      .mac_clr           (mac_clr),
      .mac_en            (mac_en)
`ifdef SEQ_PERF_EN
      ,
      .perf_cycles       (perf_cycles),
      .perf_stalls       (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Memory content: byte k of the word at address a.
   function automatic logic [7:0] bval(input logic [31:0] a, input int k);
      logic [31:0] v;
      v = a * 32'd8 + 32'(k) + 32'd1 + (a >> 8) * 32'd85;
      return v[7:0];
   endfunction

   function automatic logic [63:0] word_of(input logic [31:0] a);
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[k*8 +: 8] = bval(a, k);
      return w;
   endfunction

   typedef struct {
      int         tgt;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      bit          v;
      logic [63:0] d;
   } rp_t;

   // Model of one run: every read address and every FIFO write, in order.
   logic [31:0] exp_addr[$];
   wr_t         exp_wr[$];
   logic [31:0] cur_base;
   int          mac_cnt, last_mac, clr_cnt, a2_cnt, wr_cnt;
   bit          done_seen, hold_q, prev_done, model_on;
   logic [31:0] hold_addr;

   // Stimulus knobs
   int          stall_left, full_left;
   logic [31:0] stall_addr;
   bit          full_arm, gap_b_done, gap_a_done, stray_done;
   rp_t         pipe [3];

   initial begin
      model_on = 0; stall_left = 0; full_left = 0; full_arm = 0;
      gap_b_done = 1; gap_a_done = 1; stray_done = 1; mac_cnt = 0; a2_cnt = 0;
      stall_addr = '1; prev_done = 0; hold_q = 0;
      for (int i = 0; i < 3; i++) begin pipe[i].v = 0; pipe[i].d = '0; end
   end

   // Memory slave and FIFO-flag responder: drives inputs 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0].v = 0;
      pipe[0].d = '0;
      mem_waitrequest = 1'b0;
      if (mem_read === 1'b1) begin
         if (mem_address == stall_addr && stall_left > 0) begin
            mem_waitrequest = 1'b1;
            stall_left--;
         end else begin
            pipe[0].v = 1;
            pipe[0].d = word_of(mem_address);
         end
      end
      mem_readdatavalid = pipe[2].v;
      mem_readdata      = pipe[2].v ? pipe[2].d : 64'h0;
      if (!stray_done && mac_cnt == 1 && !pipe[2].v) begin
         mem_readdatavalid = 1'b1;
         mem_readdata      = 64'hFFEE_DDCC_BBAA_9988;
         stray_done        = 1;
      end
      if (full_arm && a2_cnt == 3) begin
         full_left = 2;
         full_arm  = 0;
      end
      fifo_wrfull_a = '0;
      if (full_left > 0) begin
         fifo_wrfull_a[2] = 1'b1;
         full_left--;
      end
      fifo_rdempty_b = (!gap_b_done && mac_cnt == 3);
      if (fifo_rdempty_b) gap_b_done = 1;
      fifo_rdempty_a0 = (!gap_a_done && mac_cnt == 5);
      if (fifo_rdempty_a0) gap_a_done = 1;
   end

   // Compare process: checks DUT outputs against the run model every falling edge.
   always @(negedge clk) begin : cmp
      int  n;
      int  got_tgt;
      wr_t e;
      logic [31:0] ea;
      if (rst_n && model_on) begin
         if (hold_q) begin
            chk("req_hold_read", mem_read, 1'b1);
            chk("req_hold_addr", mem_address, hold_addr);
         end
         hold_q    = mem_read && mem_waitrequest;
         hold_addr = mem_address;
         if (mem_read && !mem_waitrequest) begin
            chk("extra_read", exp_addr.size() > 0, 1'b1);
            if (exp_addr.size() > 0) begin
               if (exp_addr.size() == 9) chk("clr_before_first_read", clr_cnt, 1);
               ea = exp_addr.pop_front();
               chk("read_addr", mem_address, ea);
            end
         end
         n = $countones(fifo_wrreq_a) + int'(fifo_wrreq_b);
         if (n > 0) begin
            chk("one_strobe", n, 1);
            got_tgt = -1;
            for (int i = 0; i < 8; i++) if (fifo_wrreq_a[i]) got_tgt = i;
            chk("extra_write", exp_wr.size() > 0, 1'b1);
            if (exp_wr.size() > 0) begin
               e = exp_wr.pop_front();
               chk("wr_target", got_tgt, e.tgt);
               chk("wr_data", fifo_wdata, e.data);
            end
            wr_cnt++;
            if (wr_cnt == 1 && cur_base == 0) chk("first_b_byte", fifo_wdata, 8'h01);
            if (fifo_wrreq_a[2]) a2_cnt++;
         end
         if (fifo_wrfull_a[2]) begin
            chk("full_no_strobe", fifo_wrreq_a[2], 1'b0);
            chk("full_hold_byte", fifo_wdata, 8'h1C);
         end
         if (mac_clr) clr_cnt++;
         if (mac_en) begin
            chk("mac_en_nonempty", fifo_rdempty_b | fifo_rdempty_a0, 1'b0);
            chk("mac_en_after_fill", exp_wr.size() + exp_addr.size(), 0);
            mac_cnt++;
            last_mac = cyc;
            chk("mac_en_le8", mac_cnt <= 8, 1'b1);
         end else if (mac_cnt > 0 && mac_cnt < 8) begin
            chk("mac_gap_only_empty", fifo_rdempty_b | fifo_rdempty_a0, 1'b1);
         end
         if (done && !prev_done) begin
            chk("done_latency", cyc - last_mac, 8);
            chk("done_mac_count", mac_cnt, 8);
            chk("busy_low_done", busy, 1'b0);
            done_seen = 1;
         end
      end
      prev_done = (done === 1'b1);
   end

   task automatic start_run(input logic [31:0] b, input int stall, input bit full_en);
      exp_addr.delete();
      exp_wr.delete();
      for (int w = 0; w <= 8; w++) begin
         exp_addr.push_back(b + 32'(w));
         for (int k = 0; k < 8; k++) begin
            wr_t e;
            e.tgt  = w - 1;
            e.data = bval(b + 32'(w), k);
            exp_wr.push_back(e);
         end
      end
      cur_base = b; mac_cnt = 0; clr_cnt = 0; a2_cnt = 0; wr_cnt = 0;
      done_seen = 0; hold_q = 0; last_mac = 0;
      stall_left = stall; stall_addr = b + 32'd4; full_arm = full_en; full_left = 0;
      gap_b_done = 0; gap_a_done = 0; stray_done = 0;
      model_on = 1;
      @(posedge clk); #2;
      start = 1'b1;
      base_addr = b;
      @(posedge clk); #2;
      start = 1'b0;
      base_addr = 32'hDEAD_BEEF;
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 3000 && !done_seen; i++) @(posedge clk);
      chk({name, "_done_timeout"}, done_seen, 1'b1);
      #2;
      chk({name, "_all_reads"}, exp_addr.size(), 0);
      chk({name, "_all_writes"}, exp_wr.size(), 0);
      chk({name, "_mac_total"}, mac_cnt, 8);
      chk({name, "_clr_once"}, clr_cnt, 1);
      chk({name, "_done_level"}, done, 1'b1);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_done"}, done, 1'b0);
      chk({name, "_mem_read"}, mem_read, 1'b0);
      chk({name, "_mem_address"}, mem_address, 32'h0);
      chk({name, "_wdata"}, fifo_wdata, 8'h0);
      chk({name, "_wrreq_a"}, fifo_wrreq_a, 8'h0);
      chk({name, "_wrreq_b"}, fifo_wrreq_b, 1'b0);
      chk({name, "_mac_clr"}, mac_clr, 1'b0);
      chk({name, "_mac_en"}, mac_en, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Run A: base 0, 3-cycle waitrequest on word 4, A FIFO 2 full after byte 3, CALC empty gaps.
      start_run(32'h0, 3, 1'b1);
      wait_done("runA");

      // Run B: restart from DONE, abort with reset during UNPACK of word 5.
      start_run(32'h0, 0, 1'b0);
      for (int i = 0; i < 3000 && wr_cnt < 43; i++) @(posedge clk);
      chk("reached_word5", wr_cnt >= 43, 1'b1);
      #3;
      rst_n = 1'b0;
      model_on = 0;
      #1;
      check_all_zero("midrun_reset");
      repeat (2) @(posedge clk);
      #4;
      rst_n = 1'b1;

      // Run C: refetch from word 0; a start pulse during CALC must be ignored.
      start_run(32'h0, 0, 1'b0);
      for (int i = 0; i < 100 && mem_read !== 1'b1; i++) @(posedge clk);
      #2;
      chk("restart_addr0", mem_address, 32'h0);
      for (int i = 0; i < 3000 && mac_cnt < 2; i++) @(posedge clk);
      chk("reached_calc", mac_cnt >= 2, 1'b1);
      #2;
      start = 1'b1;
      base_addr = 32'h55;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done("runC");

      // Run D: start from DONE at base 0x100.
      start_run(32'h100, 0, 1'b0);
      wait_done("runD");

      // Run E: address arithmetic wraps around the top of the address space.
      start_run(32'hFFFF_FFFC, 0, 1'b0);
      wait_done("runE");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
Top-level controller for the 8x8 matrix-vector engine. It fetches ROWS+1 64-bit words from the Avalon-MM memory wrapper and unpacks each word into bytes. Word 0 goes to the B FIFO; word r+1 goes to A FIFO r. It then drives the head enable of the systolic MAC chain and signals completion once the chain has drained. The block replaces ad-hoc fill/compute sequencing in the top level.

Parameters:
ROWS, 8, number of A FIFOs / MAC elements
COLS, 8, bytes per memory word; must equal 64/DATA_WIDTH
DATA_WIDTH, 8, FIFO/MAC operand width
ADDR_WIDTH, 32, memory word-address width
MAC_LAT, 1, MAC result latency after last enable reaches tail

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin a run (ignored while busy)
base_addr  in  ADDR_WIDTH  word address of word 0; latched on accepted start
busy  out  1  high from accepted start until DONE
done  out  1  high while in DONE
mem_address  out  ADDR_WIDTH  read word address
mem_read  out  1  Avalon read request
mem_readdata  in  64  read data
mem_readdatavalid  in  1  read data valid
mem_waitrequest  in  1  slave stall
fifo_wdata  out  DATA_WIDTH  byte to selected FIFO
fifo_wrreq_a  out  ROWS  one-hot write strobe, A FIFOs
fifo_wrreq_b  out  1  write strobe, B FIFO
fifo_wrfull_a  in  ROWS  A FIFO full flags
fifo_wrfull_b  in  1  B FIFO full flag
fifo_rdempty_a0  in  1  A FIFO 0 empty
fifo_rdempty_b  in  1  B FIFO empty
mac_clr  out  1  one-cycle accumulator clear
mac_en  out  1  head enable of MAC chain (also B / A0 rdreq)

Behaviour:
- Clock and reset: single clock clk; reset rst_n asynchronous, active-low. Reset drives all outputs to 0, state to IDLE, and clears all counters.
- States: IDLE, CLEAR, REQ, WAIT, UNPACK, CALC, DRAIN, DONE.
- IDLE/DONE: start -> CLEAR; latch base_addr; word_idx=0. Start in any other state is ignored.
- CLEAR: mac_clr=1 for one cycle -> REQ.
- REQ: mem_read=1, mem_address=base+word_idx. Hold both stable while mem_waitrequest=1. Move to WAIT on the first cycle mem_waitrequest=0. At most one read outstanding.
- WAIT: mem_read=0. On mem_readdatavalid, capture mem_readdata into a 64-bit shift register -> UNPACK. mem_readdatavalid in any other state is ignored.
- UNPACK: emit bytes LSB first, one per cycle, with fifo_wdata = sreg[7:0].
  - Target is the B FIFO when word_idx=0, otherwise A FIFO word_idx-1.
  - Strobe is asserted only when the target full flag is 0. When full: no strobe, no shift, byte held.
  - After COLS bytes: if word_idx==ROWS -> CALC; else word_idx++ -> REQ.
- CALC: mac_en = !fifo_rdempty_b & !fifo_rdempty_a0. An empty FIFO stalls without counting. After COLS asserted cycles -> DRAIN.
- DRAIN: wait exactly ROWS-1+MAC_LAT cycles -> DONE.
- DONE: done=1, busy=0. The state holds until start.
- busy = state not in {IDLE, DONE}.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Reset mid-run aborts immediately. Responses to a read already in flight are ignored after reset. The next start refetches from word 0.

Optional Feature:
SEQ_PERF_EN:
- Defined: adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - perf_cycles counts cycles from accepted start to DONE entry.
  - perf_stalls counts waitrequest, full-stall and empty-stall cycles.
  - Both clear on accepted start, saturate at all-ones, and hold in DONE.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package matvec_pkg holds:
  - seq_state_t enum;
  - DATA_WIDTH, ROWS, COLS, MEM_WIDTH=64 defaults;
  - a function mapping word_idx to FIFO select.
- Sub-module word_unpacker: 64-bit load, byte serializer with full-flag backpressure and a last-byte pulse.

Test Plan:
1. base 0, zero waitrequest, readdatavalid 2 cycles after accept, word0=0x0807060504030201 -> fifo_wrreq_b strobes bytes 01..08 in order; 9 reads at addresses 0..8; A FIFO r receives word r+1 LSB first.
2. mem_waitrequest=1 for 3 cycles on word 4 -> mem_read and mem_address=4 held stable; exactly one accept; no duplicate data.
3. fifo_wrfull_a[2] high 2 cycles after byte 3 of word 3 -> fifo_wrreq_a[2] low for those cycles; byte 4 held on fifo_wdata; all 8 bytes land in order.
4. CALC with fifo_rdempty_b high 1 cycle -> mac_en has one gap; exactly 8 mac_en cycles; done rises 8 cycles (7+MAC_LAT) after the last mac_en.
5. rst_n low during UNPACK of word 5 -> all outputs 0 immediately. Next start with base 0 re-reads address 0 first.
6. start pulsed during CALC is ignored. start in DONE with base_addr=0x100 -> mac_clr pulses; addresses 0x100..0x108 issued.
